// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-indexed data memory,
// with read-modify-write for sub-word stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] ALUOut,
    output logic [31:0] reg2data,
    input  logic [31:0] memout,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        err
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; req_ready is 1 exactly when the FSM is IDLE.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RMW_RD  = 3'd2,
        RMW_WR  = 3'd3,
        WORD_WR = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic        r_rd_valid;
    logic [31:0] r_rd_data;

    logic        w_accept;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_trap;
    logic [31:0] w_align_addr;
    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_mask;
    logic [31:0] w_ins;
    logic [31:0] w_merged;

    assign w_accept  = req_valid & req_ready;
    assign w_is_word = req_size[1];
    assign w_is_half = (req_size == 2'b01);

    // Low address bits are forced aligned; when trapping is enabled the
    // misaligned request never reaches here with an effect on memory.
    assign w_align_addr = {req_addr[31:2],
                           req_addr[1] & ~w_is_word,
                           req_addr[0] & ~w_is_word & ~w_is_half};

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_err;
    assign w_misalign = (w_is_half & req_addr[0]) | (w_is_word & (req_addr[1:0] != 2'b00));
    assign w_trap     = w_misalign;
    assign err        = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= w_accept & w_trap;
    end
`else
    assign w_trap = 1'b0;
    assign err    = 1'b0;
`endif

    // Lane selection from the combinational memory word (little-endian).
    assign w_shift = {r_addr[1:0], 3'b000};
    assign w_byte  = 8'(memout >> w_shift);
    assign w_half  = r_addr[1] ? memout[31:16] : memout[15:0];

    always_comb begin
        w_load_ext = memout;
        case (r_size)
            2'b00:   w_load_ext = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            2'b01:   w_load_ext = r_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            default: w_load_ext = memout;
        endcase
    end

    // Sub-word store merge into the word sampled during RMW_RD.
    always_comb begin
        w_mask = 32'h0;
        w_ins  = 32'h0;
        if (r_size == 2'b00) begin
            w_mask = 32'h0000_00FF << w_shift;
            w_ins  = {24'h0, r_wdata[7:0]} << w_shift;
        end else begin
            w_mask = 32'h0000_FFFF << {r_addr[1], 4'b0000};
            w_ins  = {16'h0, r_wdata[15:0]} << {r_addr[1], 4'b0000};
        end
        w_merged = (r_word & ~w_mask) | w_ins;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_trap) begin
                    if (!req_we)       w_next = LOAD;
                    else if (w_is_word) w_next = WORD_WR;
                    else               w_next = RMW_RD;
                end
            end
            RMW_RD:  w_next = RMW_WR;
            LOAD,
            RMW_WR,
            WORD_WR: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUOut    = 32'h0;
        reg2data  = 32'h0;
        case (r_state)
            IDLE:    req_ready = 1'b1;
            LOAD,
            RMW_RD:  MemRead = 1'b1;
            RMW_WR: begin
                MemWrite = 1'b1;
                reg2data = w_merged;
            end
            WORD_WR: begin
                MemWrite = 1'b1;
                reg2data = r_wdata;
            end
            default: ;
        endcase
        if (r_state != IDLE) ALUOut = {2'b00, r_addr[31:2]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= 32'h0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_wdata    <= 32'h0;
            r_word     <= 32'h0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 32'h0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= (r_state == LOAD);
            if (w_accept) begin
                r_addr   <= w_align_addr;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_wdata  <= req_wdata;
            end
            if (r_state == RMW_RD) r_word <= memout;
            if (r_state == LOAD)   r_rd_data <= w_load_ext;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALUOut;
    logic [31:0] reg2data;
    logic [31:0] memout;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        err;

    int total;
    int bad;

    logic [31:0] mem [0:63];
    logic        pre_en;
    logic [5:0]  pre_a;
    logic [31:0] pre_d;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUOut(ALUOut), .reg2data(reg2data), .memout(memout),
        .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory: combinational read, write on the rising edge
    assign memout = mem[ALUOut[5:0]];
    always @(posedge clk) begin
        if (MemWrite) mem[ALUOut[5:0]] <= reg2data;
        if (pre_en)   mem[pre_a] <= pre_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // drives one request; returns #1 after the accept edge
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        pre_en = 1'b0; pre_a = 6'h0; pre_d = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_aluout", ALUOut, 32'h0);
        chk("rst_reg2data", reg2data, 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk) reset = 1'b0;

        preload(6'd8, 32'hF0F0_F0F0);
        preload(6'd10, 32'h0000_0005);
        preload(6'd5, 32'h7F80_0000);

        // signed byte load at 0x21
        issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
        chk("lb_memread", 32'(MemRead), 32'd1);
        chk("lb_aluout", ALUOut, 32'd8);
        chk("lb_ready_busy", 32'(req_ready), 32'd0);
        chk("lb_no_early_valid", 32'(rd_valid), 32'd0);
        step();
        chk("lb_rd_valid", 32'(rd_valid), 32'd1);
        chk("lb_rd_data", rd_data, 32'hFFFF_FFF0);
        chk("lb_memread_off", 32'(MemRead), 32'd0);
        step();
        chk("lb_valid_pulse", 32'(rd_valid), 32'd0);
        chk("lb_rd_hold", rd_data, 32'hFFFF_FFF0);

        // half loads at 0x22
        issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        step();
        chk("lhu_rd_data", rd_data, 32'h0000_F0F0);
        issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        step();
        chk("lh_rd_data", rd_data, 32'hFFFF_F0F0);

        // sign from lane MSB: lane 3 = 0x7F, lane 2 = 0x80
        issue(1'b0, 2'b00, 1'b1, 32'h17, 32'h0);
        step();
        chk("lb_pos_rd_data", rd_data, 32'h0000_007F);
        issue(1'b0, 2'b00, 1'b1, 32'h16, 32'h0);
        step();
        chk("lb_neg_rd_data", rd_data, 32'hFFFF_FF80);
        issue(1'b0, 2'b00, 1'b0, 32'h16, 32'h0);
        step();
        chk("lbu_rd_data", rd_data, 32'h0000_0080);

        // byte store 0x12 at 0x29
        issue(1'b1, 2'b00, 1'b0, 32'h29, 32'hAAAA_AA12);
        chk("sb_rmw_rd_memread", 32'(MemRead), 32'd1);
        chk("sb_rmw_rd_memwrite", 32'(MemWrite), 32'd0);
        chk("sb_rmw_rd_aluout", ALUOut, 32'd10);
        chk("sb_rmw_rd_ready", 32'(req_ready), 32'd0);
        step();
        chk("sb_rmw_wr_memwrite", 32'(MemWrite), 32'd1);
        chk("sb_rmw_wr_memread", 32'(MemRead), 32'd0);
        chk("sb_rmw_wr_reg2data", reg2data, 32'h0000_1205);
        chk("sb_rmw_wr_ready", 32'(req_ready), 32'd0);
        step();
        chk("sb_ready_back", 32'(req_ready), 32'd1);
        chk("sb_idle_reg2data", reg2data, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h28, 32'h0);
        step();
        chk("lw_after_sb", rd_data, 32'h0000_1205);

        // upper half store 0xABCD at 0x2A
        issue(1'b1, 2'b01, 1'b0, 32'h2A, 32'h5555_ABCD);
        step();
        chk("sh_reg2data", reg2data, 32'hABCD_1205);
        issue(1'b0, 2'b10, 1'b1, 32'h28, 32'h0);
        step();
        chk("lw_after_sh", rd_data, 32'hABCD_1205);

        // word store at 0x30
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF);
        chk("sw_memwrite", 32'(MemWrite), 32'd1);
        chk("sw_memread", 32'(MemRead), 32'd0);
        chk("sw_aluout", ALUOut, 32'd12);
        chk("sw_reg2data", reg2data, 32'hDEAD_BEEF);
        step();
        chk("sw_ready_back", 32'(req_ready), 32'd1);
        chk("sw_memwrite_off", 32'(MemWrite), 32'd0);
        chk("sw_mem12", mem[12], 32'hDEAD_BEEF);

        // misaligned word load at 0x22
        issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_memread", 32'(MemRead), 32'd0);
        chk("mis_ready", 32'(req_ready), 32'd1);
        step();
        chk("mis_err_pulse", 32'(err), 32'd0);
        chk("mis_no_rd_valid", 32'(rd_valid), 32'd0);
        chk("mis_memread2", 32'(MemRead), 32'd0);
`else
        chk("mis_aluout", ALUOut, 32'd8);
        chk("mis_err", 32'(err), 32'd0);
        step();
        chk("mis_rd_valid", 32'(rd_valid), 32'd1);
        chk("mis_rd_data", rd_data, 32'hF0F0_F0F0);
`endif

        // reset during RMW_WR must suppress the write
        preload(6'd10, 32'h0000_0005);
        issue(1'b1, 2'b00, 1'b0, 32'h29, 32'h0000_0012);
        step();
        chk("rr_memwrite_before", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("rr_memwrite_drop", 32'(MemWrite), 32'd0);
        chk("rr_aluout", ALUOut, 32'h0);
        chk("rr_reg2data", reg2data, 32'h0);
        chk("rr_rd_data", rd_data, 32'h0);
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("rr_ready", 32'(req_ready), 32'd1);
        chk("rr_mem10", mem[10], 32'h0000_0005);
        step();
        chk("rr_no_write", 32'(MemWrite), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be named clk and reset.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  rising-edge clock
  reset  in  1  async active-high reset
  req_valid  in  1  access request from EX stage; held until accepted
  req_ready  out  1  unit can accept; low = pipeline stall
  req_we  in  1  1 = store, 0 = load
  req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
  req_signed  in  1  sign-extend sub-word load
  req_addr  in  32  byte address
  req_wdata  in  32  store data, right-justified
  MemRead  out  1  read enable to data memory
  MemWrite  out  1  write enable to data memory
  ALUOut  out  32  word index to data memory
  reg2data  out  32  write word to data memory
  memout  in  32  combinational read word from data memory
  rd_valid  out  1  one-cycle load-result strobe
  rd_data  out  32  load result, extended
  err  out  1  one-cycle misaligned-access strobe

Function
REQ-003 req_ready SHALL equal (state == IDLE); a request is accepted on a rising edge with req_valid & req_ready, and all req_* fields are latched then.
REQ-004 States SHALL be IDLE, LOAD, RMW_RD, RMW_WR, WORD_WR; accept moves IDLE to LOAD (load), WORD_WR (word store) or RMW_RD (byte/half store).
REQ-005 LOAD, RMW_RD and WORD_WR SHALL last one cycle; RMW_RD goes to RMW_WR; LOAD, WORD_WR and RMW_WR go to IDLE.
REQ-006 ALUOut SHALL be {2'b00, latched_addr[31:2]} in every non-IDLE state and 0 in IDLE.
REQ-007 MemRead SHALL be 1 only in LOAD and RMW_RD, and MemWrite 1 only in WORD_WR and RMW_WR; both SHALL be 0 in IDLE.
REQ-008 memout SHALL be sampled at the edge ending LOAD or RMW_RD.
REQ-009 Lanes SHALL be little-endian: byte k = bits [8k+7:8k] with k = addr[1:0]; the half-word lane is selected by addr[1].
REQ-010 In RMW_WR, reg2data SHALL be the sampled word with only the addressed lane replaced by the low 8/16 bits of req_wdata.
REQ-011 In WORD_WR, reg2data SHALL be the latched req_wdata; otherwise reg2data SHALL be 0.
REQ-012 Load latency: rd_valid SHALL pulse high for exactly the one cycle after LOAD, i.e. two cycles after the accept edge, with rd_data valid in that cycle.
REQ-013 rd_data SHALL hold its last value until the next load completes.
REQ-014 Sub-word loads SHALL zero-extend when req_signed=0 and sign-extend from the lane MSB when req_signed=1; word loads ignore req_signed.
REQ-015 Store throughput: word store occupies 1 busy cycle, sub-word store 2, load 1; back-to-back requests are accepted on the first IDLE cycle.
REQ-016 req_valid while req_ready=0 SHALL be ignored with no side effect.

Reset
REQ-017 Asserting reset SHALL immediately force state=IDLE, MemRead=0, MemWrite=0, rd_valid=0, err=0, rd_data=0, ALUOut=0 and reg2data=0, so no write occurs at the next edge.
REQ-018 A request in flight when reset asserts SHALL be discarded, and req_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-019 Macro LSU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL be accepted, SHALL pulse err for one cycle, and SHALL stay in IDLE with no memory access and no rd_valid.
REQ-020 Macro undefined: err SHALL be tied 0, and misaligned addresses SHALL have their low bits forced aligned (half: addr[0]=0; word: addr[1:0]=0) and proceed normally.

Verification
REQ-021 Preload word 8=0xF0F0F0F0; signed byte load at 0x21 -> rd_valid two cycles after accept with rd_data=0xFFFFFFF0; MemRead high one cycle with ALUOut=8.
REQ-022 Unsigned half load at 0x22 from the same word -> rd_data=0x0000F0F0; signed -> 0xFFFFF0F0.
REQ-023 Preload word 10=0x00000005; byte store 0x12 at 0x29 -> RMW_RD then RMW_WR with reg2data=0x00001205, req_ready low 2 cycles; word load at 0x28 -> rd_data=0x00001205.
REQ-024 Word store 0xDEADBEEF at 0x30 -> single MemWrite cycle, ALUOut=12, reg2data=0xDEADBEEF, no MemRead.
REQ-025 LSU_MISALIGN_TRAP_EN defined: word load at 0x22 -> err one cycle, MemRead never high, req_ready stays 1; undefined: same request -> word 8 returned, err=0.
REQ-026 Assert reset in the RMW_WR cycle of REQ-023 -> MemWrite drops immediately and word 10 remains 0x00000005.
